decode_execute_hazard_controller: RTL
=====================================

Name: decode_execute_hazard_controller

Overview:
- Control block on the consumer side of the decode-to-execute pipeline register. It reads the execute, memory and writeback stage fields latched downstream of that register.
- Generates stall, bubble and flush controls for the fetch/decode/execute registers, plus operand-forwarding selects for the execute stage.
- Sequences multi-cycle execute operations and branch-redirect flushes.
- Keeps registered stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1: cycles that flushFetch/flushDecode stay asserted after a redirect (1..15).
- MULTI_TIMEOUT, 64: maximum MULTI_BUSY cycles before the sticky timeout error is set.
- COUNTER_WIDTH, 32: width of the performance counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- decodeRs1  in  5  rs1 of the instruction in decode
- decodeRs2  in  5  rs2 of the instruction in decode
- decodeUsesRs1  in  1  decode instruction reads rs1
- decodeUsesRs2  in  1  decode instruction reads rs2
- executeRd  in  5  rd held in the decode-to-execute register
- executeRs1  in  5  rs1 held in the decode-to-execute register
- executeRs2  in  5  rs2 held in the decode-to-execute register
- executeMemoryReadEnable  in  1  execute-stage instruction is a load
- executeRegisterWriteEnable  in  1  execute-stage instruction writes rd
- memoryRd  in  5  rd in the execute-to-memory register
- memoryRegisterWriteEnable  in  1  memory-stage instruction writes rd
- writebackRd  in  5  rd in the memory-to-writeback register
- writebackRegisterWriteEnable  in  1  writeback-stage instruction writes rd
- branchTaken  in  1  execute resolved a PC redirect (pcUpdate taken)
- multiCycleStart  in  1  execute-stage op needs multiple cycles
- multiCycleDone  in  1  multi-cycle unit result valid
- stallFetch  out  1  hold PC and the fetch-to-decode register
- stallDecode  out  1  hold the decode-to-execute register inputs
- stallExecute  out  1  hold the decode-to-execute register contents
- bubbleExecute  out  1  load a NOP (all enables 0) into the decode-to-execute register
- flushFetch  out  1  clear the fetch-to-decode register
- flushDecode  out  1  clear the decode-to-execute register
- forwardA  out  2  rs1 operand source: 00 regfile, 01 memory stage, 10 writeback stage
- forwardB  out  2  rs2 operand source: same encoding as forwardA
- timeoutError  out  1  sticky; MULTI_BUSY exceeded MULTI_TIMEOUT
- stallCount  out  COUNTER_WIDTH  total cycles with stallFetch=1
- flushCount  out  COUNTER_WIDTH  number of redirect events accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to RUN; flush and busy counters clear.
  - timeoutError=0, stallCount=0, flushCount=0.
  - All combinational outputs evaluate to 0 while in RUN with no hazards.
- Forwarding (purely combinational):
  - forwardA=01 if memoryRegisterWriteEnable && memoryRd!=0 && memoryRd==executeRs1.
  - Else forwardA=10 if the same condition holds for writeback.
  - Else 00. The memory stage has priority. forwardB uses executeRs2 with the same rules.
- Load-use hazard (loadUse): executeMemoryReadEnable && executeRegisterWriteEnable && executeRd!=0, and either (decodeUsesRs1 && executeRd==decodeRs1) or (decodeUsesRs2 && executeRd==decodeRs2).
- State RUN, priority order:
  1. branchTaken: flushFetch=flushDecode=1 this cycle. Load FLUSH counter with FLUSH_CYCLES-1. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN. flushCount += 1. branchTaken overrides loadUse and multiCycleStart.
  2. multiCycleStart && !multiCycleDone: stallFetch=stallDecode=stallExecute=1. Busy counter is set to 0. Go to MULTI_BUSY.
  3. multiCycleStart && multiCycleDone in the same cycle: no stall; stay in RUN.
  4. loadUse: stallFetch=stallDecode=1, bubbleExecute=1 for exactly this cycle. Stay in RUN; the hazard clears next cycle because a bubble has entered execute.
- State MULTI_BUSY:
  - stallFetch=stallDecode=stallExecute=1. Busy counter increments each cycle and saturates.
  - multiCycleDone: stalls deassert in that same cycle; go to RUN.
  - Busy counter reaching MULTI_TIMEOUT-1 without done: set timeoutError, then force a return to RUN.
  - branchTaken is ignored here; execute is frozen.
- State FLUSH:
  - flushFetch=flushDecode=1; counter decrements; go to RUN when it reaches 0.
  - A new branchTaken reloads the counter and increments flushCount.
  - loadUse is suppressed (decode is being flushed).
- Counters:
  - stallCount increments on every cycle with stallFetch=1.
  - Both counters wrap modulo 2^COUNTER_WIDTH.
- Register 0: rd==0 never triggers forwarding or a load-use stall.
- Reset asserted mid-MULTI_BUSY or mid-FLUSH: all outputs drop immediately (asynchronous).

Decomposition:
- Shared pipeline package holds:
  - state enum {RUN, MULTI_BUSY, FLUSH}, 2-bit encoding;
  - forward-select constants FWD_REGFILE=2'b00, FWD_MEMORY=2'b01, FWD_WRITEBACK=2'b10.
- One sub-module: hazard_forwarding_unit. It is combinational and produces forwardA, forwardB and loadUse. The parent holds the FSM and the counters.

Test Plan:
- Forwarding priority: memoryRd=5 (write=1), writebackRd=5 (write=1), executeRs1=5 → forwardA=01. Then set memoryRegisterWriteEnable=0 → forwardA=10. Then set executeRs1=0 with rd=0 on both stages → forwardA=00.
- Load-use: load in execute with executeRd=7, decodeRs2=7, decodeUsesRs2=1 → stallFetch=stallDecode=bubbleExecute=1 for one cycle, stallCount=1. With decodeUsesRs2=0 → no stall.
- Branch flush: FLUSH_CYCLES=3, branchTaken pulsed one cycle together with a loadUse → flushFetch/flushDecode high for 3 cycles, no bubbleExecute, flushCount=1.
- Multi-cycle op: multiCycleStart, then multiCycleDone 5 cycles later → stallExecute high for 5 cycles and low in the done cycle; state back to RUN. A same-cycle start+done gives no stall.
- Timeout: MULTI_TIMEOUT=8, done never arrives → timeoutError rises after 8 stall cycles, stalls release, and timeoutError stays 1 until reset.
- Asynchronous reset: assert reset=0 in the middle of MULTI_BUSY, between clock edges → all outputs 0 immediately, counters 0, RUN after release.

Source files
------------

// File: rtl/decode_execute_hazard_controller_pkg.sv
// Shared pipeline types for the decode/execute hazard controller.
package decode_execute_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MULTI_BUSY = 2'd1,
        FLUSH      = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REGFILE   = 2'b00;
    localparam logic [1:0] FWD_MEMORY    = 2'b01;
    localparam logic [1:0] FWD_WRITEBACK = 2'b10;

    // Operand source for one execute-stage register; memory stage wins over writeback.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEMORY;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WRITEBACK;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/decode_execute_hazard_controller_if.sv
// Pipeline-field inputs and hazard-control outputs of the hazard controller.
interface decode_execute_hazard_controller_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic [4:0] decodeRs1;
    logic [4:0] decodeRs2;
    logic       decodeUsesRs1;
    logic       decodeUsesRs2;
    logic [4:0] executeRd;
    logic [4:0] executeRs1;
    logic [4:0] executeRs2;
    logic       executeMemoryReadEnable;
    logic       executeRegisterWriteEnable;
    logic [4:0] memoryRd;
    logic       memoryRegisterWriteEnable;
    logic [4:0] writebackRd;
    logic       writebackRegisterWriteEnable;
    logic       branchTaken;
    logic       multiCycleStart;
    logic       multiCycleDone;

    logic       stallFetch;
    logic       stallDecode;
    logic       stallExecute;
    logic       bubbleExecute;
    logic       flushFetch;
    logic       flushDecode;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       timeoutError;
    logic [COUNTER_WIDTH-1:0] stallCount;
    logic [COUNTER_WIDTH-1:0] flushCount;

    // Pipeline side: drives stage fields, consumes controls.
    modport master (
        output decodeRs1, decodeRs2, decodeUsesRs1, decodeUsesRs2,
               executeRd, executeRs1, executeRs2,
               executeMemoryReadEnable, executeRegisterWriteEnable,
               memoryRd, memoryRegisterWriteEnable,
               writebackRd, writebackRegisterWriteEnable,
               branchTaken, multiCycleStart, multiCycleDone,
        input  stallFetch, stallDecode, stallExecute, bubbleExecute,
               flushFetch, flushDecode, forwardA, forwardB,
               timeoutError, stallCount, flushCount
    );

    // Controller side.
    modport slave (
        input  decodeRs1, decodeRs2, decodeUsesRs1, decodeUsesRs2,
               executeRd, executeRs1, executeRs2,
               executeMemoryReadEnable, executeRegisterWriteEnable,
               memoryRd, memoryRegisterWriteEnable,
               writebackRd, writebackRegisterWriteEnable,
               branchTaken, multiCycleStart, multiCycleDone,
        output stallFetch, stallDecode, stallExecute, bubbleExecute,
               flushFetch, flushDecode, forwardA, forwardB,
               timeoutError, stallCount, flushCount
    );
endinterface

// File: rtl/decode_execute_hazard_controller_hazard_forwarding_unit.sv
// Combinational forwarding selects and load-use detection.
module hazard_forwarding_unit
    import decode_execute_hazard_controller_pkg::*;
(
    input  logic       mem_we_i,
    input  logic [4:0] mem_rd_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mre_i,
    input  logic       ex_rwe_i,
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic       dec_use1_i,
    input  logic       dec_use2_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       load_use_o
);

    // A load's data is not ready until memory, so a dependent decode op must wait a cycle.
    always_comb begin
        fwd_a_o    = fwd_sel(mem_we_i, mem_rd_i, wb_we_i, wb_rd_i, ex_rs1_i);
        fwd_b_o    = fwd_sel(mem_we_i, mem_rd_i, wb_we_i, wb_rd_i, ex_rs2_i);
        load_use_o = ex_mre_i && ex_rwe_i && (ex_rd_i != 5'd0) &&
                     ((dec_use1_i && (ex_rd_i == dec_rs1_i)) ||
                      (dec_use2_i && (ex_rd_i == dec_rs2_i)));
    end

endmodule

// File: rtl/decode_execute_hazard_controller.sv
// Stall/bubble/flush sequencing, multi-cycle op tracking and perf counters.
module decode_execute_hazard_controller
    import decode_execute_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int MULTI_TIMEOUT = 64,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    decode_execute_hazard_controller_if.slave hz
);

    localparam int BW = $clog2(MULTI_TIMEOUT) + 1;
    // Timeout fires when the next busy value would hit MULTI_TIMEOUT-1, which
    // together with the start cycle yields MULTI_TIMEOUT stalled cycles.
    localparam logic [BW-1:0] BUSY_LAST    = BW'(MULTI_TIMEOUT - 2);
    localparam logic [3:0]    FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [3:0]               flush_cnt_q, flush_cnt_d;
    logic [BW-1:0]            busy_q, busy_d;
    logic                     tmo_q, tmo_d;
    logic [COUNTER_WIDTH-1:0] stall_cnt_q, flush_ev_q;

    logic       load_use;
    logic       stall_f, stall_dc, stall_e, bubble, flush_f, flush_dc, flush_inc;
    logic [1:0] fwd_a, fwd_b;

    hazard_forwarding_unit u_fwd (
        .mem_we_i   (hz.memoryRegisterWriteEnable),
        .mem_rd_i   (hz.memoryRd),
        .wb_we_i    (hz.writebackRegisterWriteEnable),
        .wb_rd_i    (hz.writebackRd),
        .ex_rs1_i   (hz.executeRs1),
        .ex_rs2_i   (hz.executeRs2),
        .ex_rd_i    (hz.executeRd),
        .ex_mre_i   (hz.executeMemoryReadEnable),
        .ex_rwe_i   (hz.executeRegisterWriteEnable),
        .dec_rs1_i  (hz.decodeRs1),
        .dec_rs2_i  (hz.decodeRs2),
        .dec_use1_i (hz.decodeUsesRs1),
        .dec_use2_i (hz.decodeUsesRs2),
        .fwd_a_o    (fwd_a),
        .fwd_b_o    (fwd_b),
        .load_use_o (load_use)
    );

    // Next-state and control outputs; redirect beats multi-cycle beats load-use.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        busy_d      = busy_q;
        tmo_d       = tmo_q;
        stall_f     = 1'b0;
        stall_dc    = 1'b0;
        stall_e     = 1'b0;
        bubble      = 1'b0;
        flush_f     = 1'b0;
        flush_dc    = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.branchTaken) begin
                    flush_f     = 1'b1;
                    flush_dc    = 1'b1;
                    flush_inc   = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (hz.multiCycleStart && !hz.multiCycleDone) begin
                    stall_f  = 1'b1;
                    stall_dc = 1'b1;
                    stall_e  = 1'b1;
                    busy_d   = '0;
                    state_d  = MULTI_BUSY;
                end else if (hz.multiCycleStart) begin
                    // Single-cycle completion: nothing to hold.
                    state_d = RUN;
                end else if (load_use) begin
                    stall_f  = 1'b1;
                    stall_dc = 1'b1;
                    bubble   = 1'b1;
                end
            end
            MULTI_BUSY: begin
                // Execute is frozen, so a redirect cannot be acted on here.
                if (hz.multiCycleDone) begin
                    state_d = RUN;
                end else begin
                    stall_f  = 1'b1;
                    stall_dc = 1'b1;
                    stall_e  = 1'b1;
                    if (busy_q == BUSY_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = RUN;
                    end else if (busy_q != '1) begin
                        busy_d = busy_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_f  = 1'b1;
                flush_dc = 1'b1;
                if (hz.branchTaken) begin
                    flush_inc   = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q <= 4'd1)
                        state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM and sequencing counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            busy_q      <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_ev_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + COUNTER_WIDTH'(stall_f);
            flush_ev_q  <= flush_ev_q + COUNTER_WIDTH'(flush_inc);
        end
    end

    assign hz.stallFetch    = stall_f;
    assign hz.stallDecode   = stall_dc;
    assign hz.stallExecute  = stall_e;
    assign hz.bubbleExecute = bubble;
    assign hz.flushFetch    = flush_f;
    assign hz.flushDecode   = flush_dc;
    assign hz.forwardA      = fwd_a;
    assign hz.forwardB      = fwd_b;
    assign hz.timeoutError  = tmo_q;
    assign hz.stallCount    = stall_cnt_q;
    assign hz.flushCount    = flush_ev_q;

endmodule
